// File: rtl/regi_arb.sv
// Round-robin two-requester write arbiter in front of an NREG x W register bank.
// Define REGI_ARB_LOCK_EN to let a winning requester hold the grant via lock0/lock1.
module regi_arb #(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int W    = 32
) (
  input  logic          En,
  input  logic          r,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic          gnt_last,
  output logic          locked,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_t;

  state_t          state_reg, state_next;
  logic            gnt_last_reg;
  logic            ack0_reg, ack1_reg;
  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic [NREG-1:0] word_we;
  logic [W-1:0]    bank_reg [NREG];

  always_ff @(posedge En) begin
    if (r) state_reg <= OPEN;
    else   state_reg <= state_next;
  end

  // wr_sel names the winner of this edge; wr_en says whether anyone wins at all.
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_sel     = gnt_last_reg;
    case (state_reg)
      OPEN: begin
        if (req0 && req1) begin
          wr_en  = 1'b1;
          wr_sel = ~gnt_last_reg;
        end else if (req0) begin
          wr_en  = 1'b1;
          wr_sel = 1'b0;
        end else if (req1) begin
          wr_en  = 1'b1;
          wr_sel = 1'b1;
        end
`ifdef REGI_ARB_LOCK_EN
        if (wr_en && !wr_sel && lock0) state_next = LOCK0;
        if (wr_en &&  wr_sel && lock1) state_next = LOCK1;
`endif
      end
`ifdef REGI_ARB_LOCK_EN
      LOCK0: begin
        wr_en  = req0;
        wr_sel = 1'b0;
        if (!lock0) state_next = OPEN;
      end
      LOCK1: begin
        wr_en  = req1;
        wr_sel = 1'b1;
        if (!lock1) state_next = OPEN;
      end
`endif
      default: state_next = OPEN;
    endcase
  end

  assign wr_addr = wr_sel ? addr1 : addr0;
  assign wr_data = wr_sel ? data1 : data0;

  always_ff @(posedge En) begin
    if (r) begin
      ack0_reg     <= 1'b0;
      ack1_reg     <= 1'b0;
      gnt_last_reg <= 1'b1;
    end else begin
      ack0_reg <= wr_en & ~wr_sel;
      ack1_reg <= wr_en &  wr_sel;
      if (wr_en) gnt_last_reg <= wr_sel;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_we
    assign word_we[gi] = wr_en && (wr_addr == AW'(gi));
  end

  always_ff @(posedge En) begin
    for (int i = 0; i < NREG; i++) begin
      if (r)               bank_reg[i] <= '0;
      else if (word_we[i]) bank_reg[i] <= wr_data;
    end
  end

  assign rdata    = bank_reg[raddr];
  assign ack0     = ack0_reg;
  assign ack1     = ack1_reg;
  assign gnt_last = gnt_last_reg;

`ifdef REGI_ARB_LOCK_EN
  assign locked = (state_reg != OPEN);
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_regi_arb.sv
// Randomised and directed bench for regi_arb against an edge-by-edge behavioural model.
module tb_regi_arb;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int W    = 32;
`ifdef REGI_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          En = 1'b0;
  logic          r;
  logic          req0, req1, lock0, lock1;
  logic [AW-1:0] addr0, addr1, raddr;
  logic [W-1:0]  data0, data1;
  logic          ack0, ack1, gnt_last, locked;
  logic [W-1:0]  rdata;

  regi_arb #(.NREG(NREG), .AW(AW), .W(W)) dut (
    .En(En), .r(r),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1),
    .gnt_last(gnt_last), .locked(locked),
    .raddr(raddr), .rdata(rdata)
  );

  always #5 En = ~En;

  int n_vec = 0;
  int n_err = 0;

  // Model: bank contents, last winner, lock owner (-1 when open), expected acks.
  logic [W-1:0] m_bank [NREG];
  bit           m_last;
  bit           m_ack0, m_ack1;
  int           m_owner;
  bit           m_valid = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int win;
    if (r) begin
      for (int i = 0; i < NREG; i++) m_bank[i] = '0;
      m_last  = 1'b1;
      m_ack0  = 1'b0;
      m_ack1  = 1'b0;
      m_owner = -1;
      m_valid = 1'b1;
      return;
    end
    win = -1;
    if (m_owner >= 0) begin
      if ((m_owner == 0) ? req0 : req1) win = m_owner;
    end else if (req0 && req1) win = m_last ? 0 : 1;
    else if (req0) win = 0;
    else if (req1) win = 1;
    if (LOCK_EN) begin
      if (m_owner >= 0) begin
        if (!((m_owner == 0) ? lock0 : lock1)) m_owner = -1;
      end else if (win >= 0 && ((win == 0) ? lock0 : lock1)) m_owner = win;
    end
    m_ack0 = (win == 0);
    m_ack1 = (win == 1);
    if (win == 0) m_bank[addr0] = data0;
    if (win == 1) m_bank[addr1] = data1;
    if (win >= 0) m_last = (win == 1);
  endtask

  // One clock: inputs already driven after a negedge; check old read, edge, then outputs.
  task automatic cycle();
    #1;
    if (m_valid) chk("rd_pre", rdata, m_bank[raddr]);
    @(posedge En);
    model_edge();
    #1;
    chk("ack0", W'(ack0), W'(m_ack0));
    chk("ack1", W'(ack1), W'(m_ack1));
    chk("gnt_last", W'(gnt_last), W'(m_last));
    chk("locked", W'(locked), W'(m_owner >= 0));
    chk("rdata", rdata, m_bank[raddr]);
    $display("t=%0t r=%b req=%b%b lock=%b%b a0=%0d a1=%0d ack=%b%b gnt_last=%b locked=%b raddr=%0d rdata=%h",
             $time, r, req0, req1, lock0, lock1, addr0, addr1, ack0, ack1, gnt_last, locked, raddr, rdata);
    @(negedge En);
  endtask

  task automatic idle();
    r = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic randomize_inputs(input bit with_reset);
    req0  = $urandom_range(0, 1);
    req1  = $urandom_range(0, 1);
    lock0 = LOCK_EN ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
    lock1 = LOCK_EN ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
    addr0 = AW'($urandom);
    addr1 = AW'($urandom);
    data0 = $urandom;
    data1 = $urandom;
    raddr = AW'($urandom);
    r     = with_reset && ($urandom_range(0, 39) == 0);
  endtask

  task automatic check_bank_zero();
    for (int i = 0; i < NREG; i++) begin
      raddr = AW'(i);
      #1 chk("bank_zero", rdata, '0);
    end
  endtask

  initial begin
    idle();
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; raddr = '0;
    @(negedge En);

    // Reset from power-up, then after random traffic.
    r = 1'b1;
    cycle();
    idle();
    check_bank_zero();
    for (int c = 0; c < 30; c++) begin
      randomize_inputs(1'b0);
      cycle();
    end
    randomize_inputs(1'b0);
    r = 1'b1;
    cycle();
    idle();
    chk("rst_gnt_last", W'(gnt_last), W'(1));
    chk("rst_ack", W'({ack0, ack1}), W'(0));
    chk("rst_locked", W'(locked), W'(0));
    check_bank_zero();

    // Single requester.
    req0 = 1'b1; addr0 = 2; data0 = 32'hDEADBEEF; raddr = 2;
    cycle();
    chk("single_ack0", W'(ack0), W'(1));
    chk("single_ack1", W'(ack1), W'(0));
    chk("single_rdata", rdata, 32'hDEADBEEF);
    req0 = 1'b0;
    cycle();
    chk("single_ack0_drop", W'(ack0), W'(0));

    // Contention from a fresh reset: grants alternate 0,1,0,1.
    r = 1'b1;
    cycle();
    idle();
    req0 = 1'b1; req1 = 1'b1; addr0 = 0; addr1 = 1;
    for (int c = 0; c < 4; c++) begin
      data0 = 32'hA000_0000 + W'(c);
      data1 = 32'hB000_0000 + W'(c);
      cycle();
      chk("rr_ack0", W'(ack0), W'(c % 2 == 0));
      chk("rr_ack1", W'(ack1), W'(c % 2 == 1));
    end
    idle();
    raddr = 0;
    #1 chk("rr_bank0", rdata, 32'hA000_0002);
    raddr = 1;
    #1 chk("rr_bank1", rdata, 32'hB000_0003);

    // Same address with gnt_last=1: requester 0 first, then requester 1.
    req0 = 1'b1; req1 = 1'b1; addr0 = 3; addr1 = 3; data0 = 1; data1 = 2; raddr = 3;
    cycle();
    chk("same_ack0", W'(ack0), W'(1));
    chk("same_val0", rdata, 32'd1);
    req0 = 1'b0;
    cycle();
    chk("same_ack1", W'(ack1), W'(1));
    chk("same_val1", rdata, 32'd2);
    idle();
    cycle();

`ifdef REGI_ARB_LOCK_EN
    // Requester 0 holds the grant for three edges while requester 1 waits.
    r = 1'b1;
    cycle();
    idle();
    req1 = 1'b1; addr1 = 1; data1 = 32'h1111_1111;
    req0 = 1'b1; lock0 = 1'b1; addr0 = 0;
    for (int c = 0; c < 3; c++) begin
      data0 = 32'hC000_0000 + W'(c);
      cycle();
      chk("lock_ack0", W'(ack0), W'(1));
      chk("lock_locked", W'(locked), W'(1));
    end
    req0 = 1'b0; lock0 = 1'b0;
    cycle();
    chk("unlock_locked", W'(locked), W'(0));
    cycle();
    chk("unlock_ack1", W'(ack1), W'(1));
    idle();

    // Reset while locked.
    req0 = 1'b1; lock0 = 1'b1; addr0 = 2; data0 = 32'h5555_AAAA;
    cycle();
    chk("lock_again", W'(locked), W'(1));
    r = 1'b1;
    cycle();
    chk("rst_mid_lock", W'(locked), W'(0));
    idle();
    check_bank_zero();
    req1 = 1'b1; addr1 = 3; data1 = 32'h0BAD_F00D;
    cycle();
    chk("post_rst_ack1", W'(ack1), W'(1));
    idle();
`endif

    // Long random run with occasional resets.
    for (int c = 0; c < 400; c++) begin
      randomize_inputs(1'b1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
